vga_scan_timing: RTL and testbench

- Display scan-timing generator for the VGA path. Drives hs/vs to the connector and hen/ven/pixel coordinates to the pixel-data stage, which paints only while hen&&ven.
- Default mode is 800x600@72Hz with a 50 MHz pclk.
- The pixel-data stage counts exactly H_ACT x V_ACT enabled cycles per frame. This block must guarantee exactly that count per frame, with no glitch cycles.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/scan_counter.sv | 16 +
 rtl/vga_scan_timing.sv | 81 ++++++++
 tb/tb_vga_scan_timing.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA mode constants (800x600@72, 640x480@60), totals and counter/coordinate widths
package vga_timing_pkg;
  localparam int COORD_W = 10;
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int SVGA_H_ACT = 800;
  localparam int SVGA_H_FP = 56;
  localparam int SVGA_H_SYNC = 120;
  localparam int SVGA_H_BP = 64;
  localparam int SVGA_V_ACT = 600;
  localparam int SVGA_V_FP = 37;
  localparam int SVGA_V_SYNC = 6;
  localparam int SVGA_V_BP = 23;
  localparam int SVGA_H_TOTAL = SVGA_H_SYNC + SVGA_H_BP + SVGA_H_ACT + SVGA_H_FP;
  localparam int SVGA_V_TOTAL = SVGA_V_SYNC + SVGA_V_BP + SVGA_V_ACT + SVGA_V_FP;
  localparam int VGA_H_ACT = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACT = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BP + VGA_H_ACT + VGA_H_FP;
  localparam int VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BP + VGA_V_ACT + VGA_V_FP;
endpackage

// File: rtl/scan_counter.sv
// scan_counter: modulo-MOD counter; ports pclk, rstn (sync active-low), en, cnt, wrap (en on the last count)
module scan_counter #(
  parameter int W = 11,
  parameter int MOD = 1040
) (
  input  logic         pclk,
  input  logic         rstn,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(MOD - 1);
  always_comb wrap = en && cnt == LAST;
  always_ff @(posedge pclk)
    cnt <= !rstn ? '0 : wrap ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: VGA scan timing; in pclk/rstn (sync active-low), out hs/vs sync, hen/ven enables, pixel_x/pixel_y, sof/eol pulses, frame_cnt -- all registered, 1 pclk after counters
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACT = SVGA_H_ACT,
  parameter int H_FP = SVGA_H_FP,
  parameter int H_SYNC = SVGA_H_SYNC,
  parameter int H_BP = SVGA_H_BP,
  parameter int V_ACT = SVGA_V_ACT,
  parameter int V_FP = SVGA_V_FP,
  parameter int V_SYNC = SVGA_V_SYNC,
  parameter int V_BP = SVGA_V_BP,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic               pclk,
  input  logic               rstn,
  output logic               hs,
  output logic               vs,
  output logic               hen,
  output logic               ven,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               sof,
  output logic               eol,
  output logic [7:0]         frame_cnt
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam logic [HCNT_W-1:0] H_SYNC_END = HCNT_W'(H_SYNC);
  localparam logic [HCNT_W-1:0] H_START = HCNT_W'(H_SYNC + H_BP);
  localparam logic [HCNT_W-1:0] H_END = HCNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [VCNT_W-1:0] V_SYNC_END = VCNT_W'(V_SYNC);
  localparam logic [VCNT_W-1:0] V_START = VCNT_W'(V_SYNC + V_BP);
  localparam logic [VCNT_W-1:0] V_END = VCNT_W'(V_SYNC + V_BP + V_ACT);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACT - 1);
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic h_wrap, v_wrap_unused;
  logic hs_i, vs_i, hen_i, ven_i, act_i, sof_i, eol_i;
  logic [COORD_W-1:0] hx, vy;
  scan_counter #(.W(HCNT_W), .MOD(H_TOTAL)) u_hcnt (
    .pclk(pclk), .rstn(rstn), .en(1'b1), .cnt(hcnt), .wrap(h_wrap)
  );
  scan_counter #(.W(VCNT_W), .MOD(V_TOTAL)) u_vcnt (
    .pclk(pclk), .rstn(rstn), .en(h_wrap), .cnt(vcnt), .wrap(v_wrap_unused)
  );
  always_comb begin
    hs_i = hcnt < H_SYNC_END;
    vs_i = vcnt < V_SYNC_END;
    hen_i = hcnt >= H_START && hcnt < H_END;
    ven_i = vcnt >= V_START && vcnt < V_END;
    act_i = hen_i && ven_i;
    hx = act_i ? COORD_W'(hcnt - H_START) : '0;
    vy = act_i ? COORD_W'(vcnt - V_START) : '0;
    sof_i = act_i && hx == '0 && vy == '0;
    eol_i = act_i && hx == X_LAST;
  end
  always_ff @(posedge pclk)
    if (!rstn) begin
      hs <= ~HS_POL;
      vs <= ~VS_POL;
      hen <= 1'b0;
      ven <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
      sof <= 1'b0;
      eol <= 1'b0;
      frame_cnt <= '0;
    end else begin
      hs <= hs_i ~^ HS_POL;
      vs <= vs_i ~^ VS_POL;
      hen <= hen_i;
      ven <= ven_i;
      pixel_x <= hx;
      pixel_y <= vy;
      sof <= sof_i;
      eol <= eol_i;
      frame_cnt <= frame_cnt + 8'(sof_i);
    end
endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: directed checks of vga_scan_timing in a reduced 8x5 mode (15 pclk lines, 10-line frames)
module tb_vga_scan_timing;
  logic pclk = 1'b0;
  logic rstn = 1'b0;
  logic hs, vs, hen, ven, sof, eol;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] frame_cnt;
  int tests = 0;
  int failed = 0;
  int p = 0;
  vga_scan_timing #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACT(5), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pclk(pclk), .rstn(rstn), .hs(hs), .vs(vs), .hen(hen), .ven(ven),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .sof(sof), .eol(eol), .frame_cnt(frame_cnt)
  );
  always #5 pclk = ~pclk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic adv_to(input int target);
    while (p < target) begin
      @(negedge pclk);
      p++;
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_hs"}, 32'(hs), 0);
    check({tag, "_vs"}, 32'(vs), 0);
    check({tag, "_hen"}, 32'(hen), 0);
    check({tag, "_ven"}, 32'(ven), 0);
    check({tag, "_px"}, 32'(pixel_x), 0);
    check({tag, "_py"}, 32'(pixel_y), 0);
    check({tag, "_sof"}, 32'(sof), 0);
    check({tag, "_eol"}, 32'(eol), 0);
    check({tag, "_fc"}, 32'(frame_cnt), 0);
  endtask
  task automatic measure(input int base, input string tag);
    int n_act = 0, n_hen = 0, n_eol = 0, n_sof = 0, n_hs = 0, n_vs = 0;
    int sx = 0, sy = 0, run = 0, bad = 0;
    for (int i = 0; i < 150; i++) begin
      adv_to(base + i);
      n_hen += int'(hen);
      n_eol += int'(eol);
      n_sof += int'(sof);
      n_hs += int'(hs);
      n_vs += int'(vs);
      if (hen && ven) begin
        n_act++;
        run++;
        sx += int'(pixel_x);
        sy += int'(pixel_y);
        if (sof && (pixel_x != 0 || pixel_y != 0)) bad++;
      end else begin
        if (run != 0 && run != 8) bad++;
        run = 0;
      end
    end
    check({tag, "_active"}, n_act, 40);
    check({tag, "_hen"}, n_hen, 80);
    check({tag, "_eol"}, n_eol, 5);
    check({tag, "_sof"}, n_sof, 1);
    check({tag, "_hs_hi"}, n_hs, 30);
    check({tag, "_vs_hi"}, n_vs, 30);
    check({tag, "_sumx"}, sx, 140);
    check({tag, "_sumy"}, sy, 80);
    check({tag, "_lines"}, bad, 0);
  endtask
  initial begin
    repeat (3) @(negedge pclk);
    check_reset("rst");
    rstn = 1'b1;
    p = -1;
    adv_to(0);
    check("p0_hs", 32'(hs), 1);
    check("p0_vs", 32'(vs), 1);
    check("p0_hen", 32'(hen), 0);
    check("p0_fc", 32'(frame_cnt), 0);
    adv_to(2);
    check("p2_hs", 32'(hs), 1);
    adv_to(3);
    check("p3_hs", 32'(hs), 0);
    adv_to(20);
    check("vblank_hen", 32'(hen), 1);
    check("vblank_ven", 32'(ven), 0);
    check("vblank_px", 32'(pixel_x), 0);
    adv_to(29);
    check("vs_last", 32'(vs), 1);
    adv_to(30);
    check("vs_off", 32'(vs), 0);
    adv_to(49);
    check("pre_sof", 32'(sof), 0);
    check("pre_hen", 32'(hen), 0);
    check("pre_fc", 32'(frame_cnt), 0);
    adv_to(50);
    check("sof", 32'(sof), 1);
    check("sof_hen", 32'(hen), 1);
    check("sof_ven", 32'(ven), 1);
    check("sof_px", 32'(pixel_x), 0);
    check("sof_py", 32'(pixel_y), 0);
    check("sof_fc", 32'(frame_cnt), 1);
    adv_to(51);
    check("post_sof", 32'(sof), 0);
    check("x1", 32'(pixel_x), 1);
    adv_to(57);
    check("eol", 32'(eol), 1);
    check("eol_px", 32'(pixel_x), 7);
    adv_to(58);
    check("post_eol", 32'(eol), 0);
    check("fp_hen", 32'(hen), 0);
    adv_to(117);
    check("last_eol", 32'(eol), 1);
    check("last_py", 32'(pixel_y), 4);
    adv_to(125);
    check("vfp_ven", 32'(ven), 0);
    check("vfp_hen", 32'(hen), 1);
    check("vfp_py", 32'(pixel_y), 0);
    adv_to(149);
    check("end_hs", 32'(hs), 0);
    check("end_vs", 32'(vs), 0);
    adv_to(150);
    check("wrap_hs", 32'(hs), 1);
    check("wrap_vs", 32'(vs), 1);
    measure(150, "f2");
    check("f2_fc", 32'(frame_cnt), 2);
    adv_to(384);
    check("mid_px", 32'(pixel_x), 4);
    check("mid_py", 32'(pixel_y), 2);
    rstn = 1'b0;
    adv_to(385);
    check_reset("mid1");
    adv_to(387);
    check_reset("mid3");
    rstn = 1'b1;
    p = -1;
    adv_to(0);
    check("rel_hs", 32'(hs), 1);
    check("rel_vs", 32'(vs), 1);
    measure(0, "rel");
    check("rel_fc", 32'(frame_cnt), 1);
    adv_to(254 * 150 + 50);
    check("fc255_sof", 32'(sof), 1);
    check("fc255", 32'(frame_cnt), 255);
    adv_to(255 * 150 - 1);
    check("pre_wrap_fc", 32'(frame_cnt), 255);
    check("pre_wrap_vs", 32'(vs), 0);
    adv_to(255 * 150);
    check("f255_wrap_hs", 32'(hs), 1);
    check("f255_wrap_vs", 32'(vs), 1);
    adv_to(255 * 150 + 50);
    check("fc_wrap_sof", 32'(sof), 1);
    check("fc_wrap", 32'(frame_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
